// File: rtl/otter_lsu.sv
// Load/store unit driving the synchronous one-cycle dmem port; one request in flight.
// Loads respond two edges after accept; stores and errors respond after one edge.
module otter_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              dmem_r_en,
  output logic              dmem_w_en,
  output logic [3:0]        dmem_w_strb,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_w_data,
  input  logic [DATA_W-1:0] dmem_r_data
);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RESP} state_t;

  state_t            state, state_d;
  logic [1:0]        off_q, off_d;
  logic [2:0]        f3_q, f3_d;
  logic              resp_valid_d, resp_err_d;
  logic [DATA_W-1:0] resp_data_d;
  logic              misaligned, illegal, err, drive, accept;
  logic [DATA_W-1:0] shifted, load_ext;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    if (req_we) illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
    else        illegal = req_funct3 inside {3'b011, 3'b110, 3'b111};
  end

  assign err   = misaligned || illegal;
  assign drive = req_valid && (state == IDLE) && !err && !rst;

  // Faulting or idle cycles leave the whole dmem port at zero.
  always_comb begin
    dmem_r_en   = drive && !req_we;
    dmem_w_en   = drive && req_we;
    dmem_w_strb = 4'b0000;
    dmem_w_data = '0;
    dmem_addr   = '0;
    if (drive) dmem_addr = {req_addr[ADDR_W-1:2], 2'b00};
    if (dmem_w_en) begin
      case (req_funct3[1:0])
        2'b00: begin
          dmem_w_strb = 4'b0001 << req_addr[1:0];
          dmem_w_data = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          dmem_w_strb = 4'b0011 << req_addr[1:0];
          dmem_w_data = {2{req_wdata[15:0]}};
        end
        default: begin
          dmem_w_strb = 4'b1111;
          dmem_w_data = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = dmem_r_data >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      3'b101:  load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      default: load_ext = dmem_r_data;
    endcase
  end

  always_comb begin
    state_d      = state;
    off_d        = off_q;
    f3_d         = f3_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_data_d  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (err) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            state_d      = RESP;
          end else if (req_we) begin
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end else begin
            off_d   = req_addr[1:0];
            f3_d    = req_funct3;
            state_d = LOAD_WAIT;
          end
        end
      end
      LOAD_WAIT: begin
        resp_valid_d = 1'b1;
        resp_data_d  = load_ext;
        state_d      = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      state      <= state_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_data  <= resp_data_d;
    end
  end

endmodule
